dmem_arbiter: RTL and testbench

//   Shares the single-ported Data_Memory between two requesters: port 0 (CPU

---
 rtl/dmem_arbiter.sv | 155 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported data memory, with a
// registered issue stage and fixed-latency read return. Define DMARB_FIXED_PRIO_EN to give port 0 fixed priority.
module dmem_arbiter #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          req0_i,
  input  logic          we0_i,
  input  logic [AW-1:0] addr0_i,
  input  logic [DW-1:0] wdata0_i,
  output logic          gnt0_o,
  output logic          rvalid0_o,
  input  logic          req1_i,
  input  logic          we1_i,
  input  logic [AW-1:0] addr1_i,
  input  logic [DW-1:0] wdata1_i,
  output logic          gnt1_o,
  output logic          rvalid1_o,
  output logic [DW-1:0] rdata_o,
  output logic          mem_en_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i
);

  // state  | meaning
  // IDLE   | sample requests, latch the winning port's access
  // ISSUE  | drive the memory strobe and grant the winner for one cycle
  // WAIT   | count out the memory read latency, capture read data on the last cycle
  // RESP   | pulse rvalid for the winner, read data held in rdata_o
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  localparam logic [1:0] LAT_M1 = 2'(MEM_LAT - 1);

  state_e        state_q, state_d;
  logic          win_q, win_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          pick1;
`ifndef DMARB_FIXED_PRIO_EN
  logic          rr_q, rr_d;
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      win_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= 2'd0;
      rdata_q <= '0;
`ifndef DMARB_FIXED_PRIO_EN
      rr_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
`ifndef DMARB_FIXED_PRIO_EN
      rr_q    <= rr_d;
`endif
    end
  end

  // Port 1 wins when it is the only requester, or on a tie when the pointer is on it.
`ifdef DMARB_FIXED_PRIO_EN
  assign pick1 = req1_i && !req0_i;
`else
  assign pick1 = req1_i && (!req0_i || rr_q);
`endif

  always_comb begin
    state_d     = state_q;
    win_d       = win_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
`ifndef DMARB_FIXED_PRIO_EN
    rr_d        = rr_q;
`endif
    gnt0_o      = 1'b0;
    gnt1_o      = 1'b0;
    rvalid0_o   = 1'b0;
    rvalid1_o   = 1'b0;
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;

    case (state_q)
      S_IDLE: begin
        if (req0_i || req1_i) begin
          win_d   = pick1;
          we_d    = pick1 ? we1_i    : we0_i;
          addr_d  = pick1 ? addr1_i  : addr0_i;
          wdata_d = pick1 ? wdata1_i : wdata0_i;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        gnt0_o      = !win_q;
        gnt1_o      = win_q;
        mem_en_o    = 1'b1;
        mem_we_o    = we_q;
        mem_addr_o  = addr_q;
        mem_wdata_o = wdata_q;
`ifndef DMARB_FIXED_PRIO_EN
        rr_d        = !win_q;
`endif
        if (we_q) begin
          state_d = S_IDLE;
        end else begin
          cnt_d   = 2'd0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == LAT_M1) begin
          rdata_d = mem_rdata_i;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      S_RESP: begin
        rvalid0_o = !win_q;
        rvalid1_o = win_q;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rdata_o = rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: one instance at MEM_LAT=1 (A), one at MEM_LAT=3 (B),
// each with its own behavioural memory.
module tb_dmem_arbiter;

  logic clk_i = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk_i = ~clk_i;

  int ntests = 0;
  int nfail  = 0;

  logic        a_req0 = 0, a_we0 = 0, a_req1 = 0, a_we1 = 0;
  logic [31:0] a_addr0 = 0, a_wdata0 = 0, a_addr1 = 0, a_wdata1 = 0;
  logic        a_gnt0, a_gnt1, a_rv0, a_rv1, a_en, a_we;
  logic [31:0] a_rdata, a_maddr, a_mwdata, a_mrdata;

  logic        b_req0 = 0, b_we0 = 0, b_req1 = 0, b_we1 = 0;
  logic [31:0] b_addr0 = 0, b_wdata0 = 0, b_addr1 = 0, b_wdata1 = 0;
  logic        b_gnt0, b_gnt1, b_rv0, b_rv1, b_en, b_we;
  logic [31:0] b_rdata, b_maddr, b_mwdata, b_mrdata;

  dmem_arbiter #(.AW(32), .DW(32), .MEM_LAT(1)) u_a (
    .clk_i(clk_i), .rst_i(rst_n),
    .req0_i(a_req0), .we0_i(a_we0), .addr0_i(a_addr0), .wdata0_i(a_wdata0),
    .gnt0_o(a_gnt0), .rvalid0_o(a_rv0),
    .req1_i(a_req1), .we1_i(a_we1), .addr1_i(a_addr1), .wdata1_i(a_wdata1),
    .gnt1_o(a_gnt1), .rvalid1_o(a_rv1),
    .rdata_o(a_rdata), .mem_en_o(a_en), .mem_we_o(a_we),
    .mem_addr_o(a_maddr), .mem_wdata_o(a_mwdata), .mem_rdata_i(a_mrdata)
  );

  dmem_arbiter #(.AW(32), .DW(32), .MEM_LAT(3)) u_b (
    .clk_i(clk_i), .rst_i(rst_n),
    .req0_i(b_req0), .we0_i(b_we0), .addr0_i(b_addr0), .wdata0_i(b_wdata0),
    .gnt0_o(b_gnt0), .rvalid0_o(b_rv0),
    .req1_i(b_req1), .we1_i(b_we1), .addr1_i(b_addr1), .wdata1_i(b_wdata1),
    .gnt1_o(b_gnt1), .rvalid1_o(b_rv1),
    .rdata_o(b_rdata), .mem_en_o(b_en), .mem_we_o(b_we),
    .mem_addr_o(b_maddr), .mem_wdata_o(b_mwdata), .mem_rdata_i(b_mrdata)
  );

  // Behavioural memories: read data appears MEM_LAT cycles after the strobe cycle.
  logic [31:0] mem_a [0:255];
  logic [31:0] mem_b [0:255];
  logic [31:0] pipe_a;
  logic [31:0] pipe_b [0:2];

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = 32'h0;
      mem_b[i] = 32'h0;
    end
    pipe_a = 32'h0;
    for (int i = 0; i < 3; i++) pipe_b[i] = 32'h0;
  end

  always @(posedge clk_i) begin
    if (a_en && a_we) mem_a[a_maddr[7:0]] <= a_mwdata;
    pipe_a <= mem_a[a_maddr[7:0]];
    if (b_en && b_we) mem_b[b_maddr[7:0]] <= b_mwdata;
    pipe_b[0] <= mem_b[b_maddr[7:0]];
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end

  assign a_mrdata = pipe_a;
  assign b_mrdata = pipe_b[2];

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  int ng;
  logic two_gnt;
  logic ord [0:3];
  int cyc [0:3];
  logic exp_ord [0:3];
  logic seen;

  initial begin
    rst_n = 1'b0;
    tick(); tick();
    chk("reset_a_outs", {a_gnt0, a_gnt1, a_rv0, a_rv1, a_en, a_we}, 64'h0);
    chk("reset_a_rdata", a_rdata, 64'h0);
    rst_n = 1'b1;
    tick();

    // 1: reset while B sits in WAIT
    b_req1 = 1; b_we1 = 0; b_addr1 = 32'h20;
    tick();
    chk("t1_gnt1_pre", b_gnt1, 1'b1);
    b_req1 = 0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("t1_rst_outs", {b_gnt0, b_gnt1, b_rv0, b_rv1, b_en, b_we}, 64'h0);
    chk("t1_rst_bus", {b_maddr, b_mwdata}, 64'h0);
    chk("t1_rst_rdata", b_rdata, 64'h0);
    tick();
    rst_n = 1'b1;
    b_req1 = 1; b_we1 = 1; b_addr1 = 32'h30; b_wdata1 = 32'hAB;
    tick();
    chk("t1_gnt1", {b_gnt0, b_gnt1}, 64'h1);
    b_req1 = 0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (b_gnt0 || b_gnt1 || b_rv0 || b_rv1) seen = 1'b1;
    end
    chk("t1_no_stale", seen, 1'b0);

    // 2: write on A port 0
    a_req0 = 1; a_we0 = 1; a_addr0 = 32'h10; a_wdata0 = 32'h55;
    tick();
    chk("t2_gnt", {a_gnt0, a_gnt1}, 64'h2);
    chk("t2_en_we", {a_en, a_we}, 64'h3);
    chk("t2_addr", a_maddr, 64'h10);
    chk("t2_wdata", a_mwdata, 64'h55);
    a_req0 = 0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (a_rv0 || a_gnt0 || a_en) seen = 1'b1;
    end
    chk("t2_quiet", seen, 1'b0);

    // 3a: read on A port 1, MEM_LAT=1
    a_req1 = 1; a_we1 = 0; a_addr1 = 32'h10;
    tick();
    chk("t3a_gnt1", {a_gnt1, a_en, a_we}, 64'h6);
    chk("t3a_addr", a_maddr, 64'h10);
    a_req1 = 0;
    tick();
    chk("t3a_p2", {a_rv0, a_rv1, a_en}, 64'h0);
    tick();
    chk("t3a_rvalid", {a_rv0, a_rv1, a_gnt0, a_gnt1}, 64'h4);
    chk("t3a_rdata", a_rdata, 64'h55);
    tick();
    chk("t3a_p4", {a_rv0, a_rv1}, 64'h0);
    chk("t3a_hold", a_rdata, 64'h55);

    // 3b + 6: read on B port 1, MEM_LAT=3, with a one-cycle req0 pulse in WAIT
    b_req0 = 1; b_we0 = 1; b_addr0 = 32'h10; b_wdata0 = 32'h55;
    tick();
    chk("t3b_wr_gnt", b_gnt0, 1'b1);
    b_req0 = 0;
    tick();
    b_req1 = 1; b_we1 = 0; b_addr1 = 32'h10;
    tick();
    chk("t3b_gnt1", {b_gnt1, b_en, b_we}, 64'h6);
    b_req1 = 0;
    b_req0 = 1; b_we0 = 0; b_addr0 = 32'h44;
    tick();
    b_req0 = 0;
    chk("t3b_p2", b_rv1, 1'b0);
    tick();
    chk("t3b_p3", b_rv1, 1'b0);
    tick();
    chk("t3b_p4", b_rv1, 1'b0);
    tick();
    chk("t3b_rvalid", {b_rv0, b_rv1}, 64'h1);
    chk("t3b_rdata", b_rdata, 64'h55);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (b_gnt0 || b_rv0 || b_rv1) seen = 1'b1;
    end
    chk("t6_no_gnt0", seen, 1'b0);

    // 4/5: both ports held; four grants
`ifdef DMARB_FIXED_PRIO_EN
    exp_ord[0] = 0; exp_ord[1] = 0; exp_ord[2] = 0; exp_ord[3] = 1;
`else
    exp_ord[0] = 0; exp_ord[1] = 1; exp_ord[2] = 0; exp_ord[3] = 1;
`endif
    a_req0 = 1; a_we0 = 1; a_addr0 = 32'h40; a_wdata0 = 32'h1234;
    a_req1 = 1; a_we1 = 1; a_addr1 = 32'h44; a_wdata1 = 32'h5678;
    ng = 0;
    two_gnt = 1'b0;
    for (int c = 1; c <= 20 && ng < 4; c++) begin
      tick();
      if (a_gnt0 && a_gnt1) two_gnt = 1'b1;
      if (a_gnt0 || a_gnt1) begin
        ord[ng] = a_gnt1;
        cyc[ng] = c;
        ng++;
`ifdef DMARB_FIXED_PRIO_EN
        if (ng == 3) a_req0 = 0;
`endif
        if (ng == 4) begin
          a_req0 = 0;
          a_req1 = 0;
        end
      end
    end
    chk("t4_ngrants", ng, 4);
    chk("t4_two_gnt", two_gnt, 1'b0);
    for (int i = 0; i < 4; i++) begin
      if (i < ng) begin
        chk($sformatf("t4_order%0d", i), ord[i], exp_ord[i]);
        chk($sformatf("t4_cycle%0d", i), cyc[i], 2 * i + 1);
      end
    end
    tick();
    chk("t4_mem_last", mem_a[8'h44], 64'h5678);
    chk("t4_mem_first", mem_a[8'h40], 64'h1234);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
